// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small valid/ready input FIFO.
// Frames (start, data LSB first, optional parity, stop) are sent back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_BITS-1:0]             data_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic                             tx,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BAUD_W    = $clog2(STOP_CLKS);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_next;
  logic [BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_bit, par_next;
  logic                 tx_next;
  logic                 pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [DATA_BITS-1:0] head;
  logic                 wr_en;
  logic                 fifo_empty;
  logic                 bit_end, stop_end, last_data;

  assign ready_out  = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign wr_en      = valid_in && ready_out && !rst;
  assign head       = mem[rd_ptr];

  assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign stop_end  = (baud_cnt == BAUD_W'(STOP_CLKS - 1));
  assign last_data = (bit_cnt == BIT_W'(DATA_BITS - 1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_STOP) && stop_end;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_next;
      tx       <= tx_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      par_bit  <= par_next;
    end
  end

  // A pop loads the shifter and latches parity from the popped word, so later
  // changes on data_in or the FIFO cannot disturb the frame in flight.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    baud_next  = baud_cnt + BAUD_W'(1);
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par_bit;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          tx_next    = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (last_data) begin
            if (PARITY != 0) begin
              state_next = S_PAR;
              tx_next    = par_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            shift_next = shift >> 1;
            tx_next    = shift[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        baud_next  = '0;
      end
    endcase

    if (pop) begin
      shift_next = head;
      par_next   = (^head) ^ (PARITY == 2);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter configurations checked every cycle against a frame-level
// queue model, plus directed frames with hand-computed line levels.
module tb_uart_tx_fifo;

  logic             clk;
  logic             rst;
  logic [2:0]       vin;
  logic [2:0][8:0]  din;
  logic [2:0]       rdy, txo, bsy, dn;
  logic [2:0][2:0]  cnt;

  int checks = 0;
  int errors = 0;

  // instance 0: 8 bits even parity 1 stop; 1: 8 bits odd parity 1 stop; 2: 7 bits no parity 2 stop
  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .data_in(din[0][7:0]), .valid_in(vin[0]), .ready_out(rdy[0]),
    .tx(txo[0]), .busy(bsy[0]), .done(dn[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .data_in(din[1][7:0]), .valid_in(vin[1]), .ready_out(rdy[1]),
    .tx(txo[1]), .busy(bsy[1]), .done(dn[1]), .fifo_count(cnt[1]));
  uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .data_in(din[2][6:0]), .valid_in(vin[2]), .ready_out(rdy[2]),
    .tx(txo[2]), .busy(bsy[2]), .done(dn[2]), .fifo_count(cnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int db(input int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int par(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
  endfunction
  function automatic int sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int flen(input int i);
    return (1 + db(i) + ((par(i) != 0) ? 1 : 0) + sb(i)) * 4;
  endfunction

  // Model: a word queue per instance and the position inside the current frame.
  int mq [3][4];
  int mhead [3];
  int msize [3];
  int mt [3];
  int mcur [3];
  bit mact [3];
  bit model_on = 1'b0;

  function automatic bit exp_tx(input int i);
    int b;
    if (!mact[i]) return 1'b1;
    b = mt[i] / 4;
    if (b == 0) return 1'b0;
    if (b <= db(i)) return bit'((mcur[i] >> (b - 1)) & 1);
    if (par(i) != 0 && b == db(i) + 1)
      return bit'(($countones(mcur[i]) % 2) ^ ((par(i) == 2) ? 1 : 0));
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
        mhead[i] = 0; msize[i] = 0; mact[i] = 1'b0; mt[i] = 0; mcur[i] = 0;
      end
    end else if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        bit wr, fin;
        wr  = vin[i] && (msize[i] != 4);
        fin = mact[i] && (mt[i] == flen(i) - 1);
        if (mact[i] && !fin) begin
          mt[i]++;
        end else if (msize[i] > 0) begin
          mcur[i]  = mq[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 4;
          msize[i]--;
          mact[i]  = 1'b1;
          mt[i]    = 0;
        end else begin
          mact[i] = 1'b0;
        end
        if (wr) begin
          mq[i][(mhead[i] + msize[i]) % 4] = int'(din[i]) & ((1 << db(i)) - 1);
          msize[i]++;
        end
      end
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        chk("tx", i, txo[i], exp_tx(i));
        chk("busy", i, bsy[i], mact[i]);
        chk("done", i, dn[i], mact[i] && (mt[i] == flen(i) - 1));
        chk("ready_out", i, rdy[i], msize[i] != 4);
        chk("fifo_count", i, cnt[i], msize[i]);
      end
    end
  end

  logic [10:0] seq0;
  logic [9:0]  seq2;
  int n_done, n_busy, n_low;

  initial begin
    seq0 = {1'b1, 1'b0, 8'hAA, 1'b0};
    seq2 = {2'b11, 7'h55, 1'b0};
    rst = 1'b1;
    vin = '0;
    din = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 0, txo[0], 1);
    chk("rst_ready", 0, rdy[0], 1);
    chk("rst_busy", 0, bsy[0], 0);
    chk("rst_done", 0, dn[0], 0);
    chk("rst_count", 0, cnt[0], 0);
    rst = 1'b0;

    // one word to each instance: AA even parity, 01 odd parity, 55 in 7N2
    @(negedge clk);
    din[0] = 9'h0AA; din[1] = 9'h001; din[2] = 9'h055;
    vin = 3'b111;
    @(negedge clk);
    vin = '0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (j < 44) chk("aa_line", 0, txo[0], seq0[j / 4]);
      chk("aa_done", 0, dn[0], j == 43);
      if (j == 38) chk("odd_parity_01", 1, txo[1], 0);
      if (j < 40) chk("w7_line", 2, txo[2], seq2[j / 4]);
      chk("w7_done", 2, dn[2], j == 39);
      if (j == 40) chk("w7_busy_after", 2, bsy[2], 0);
    end
    chk("aa_busy_after", 0, bsy[0], 0);

    din[0] = 9'h001;
    vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    for (int j = 0; j < 44; j++) begin
      @(negedge clk);
      if (j == 38) chk("even_parity_01", 0, txo[0], 1);
    end

    // six-cycle burst: five accepted, sixth dropped while full
    n_done = 0; n_busy = 0;
    for (int i = 1; i <= 6; i++) begin
      din[0] = 9'(i);
      vin[0] = 1'b1;
      if (i == 6) chk("ready_when_full", 0, rdy[0], 0);
      @(negedge clk);
      n_done += int'(dn[0]); n_busy += int'(bsy[0]);
    end
    vin[0] = 1'b0;
    repeat (224) begin
      @(negedge clk);
      n_done += int'(dn[0]); n_busy += int'(bsy[0]);
    end
    chk("burst_done_pulses", 0, n_done, 5);
    chk("burst_busy_cycles", 0, n_busy, 220);

    // reset during the third data bit of the first of three queued frames
    for (int i = 0; i < 3; i++) begin
      din[0] = 9'(8'h30 + i);
      vin[0] = 1'b1;
      @(negedge clk);
    end
    vin[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_count", 0, cnt[0], 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 0, txo[0], 1);
    chk("midrst_busy", 0, bsy[0], 0);
    chk("midrst_count", 0, cnt[0], 0);
    chk("midrst_done", 0, dn[0], 0);
    rst = 1'b0;
    n_done = 0; n_low = 0;
    repeat (100) begin
      @(negedge clk);
      n_done += int'(dn[0]); n_low += int'(!txo[0]);
    end
    chk("post_rst_done", 0, n_done, 0);
    chk("post_rst_line_low", 0, n_low, 0);

    // randomized traffic alternating sparse and bursty phases, with rare resets
    for (int c = 0; c < 4000; c++) begin
      int p;
      @(negedge clk);
      p = (((c / 400) % 2) != 0) ? 85 : 3;
      rst = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < 3; i++) begin
        vin[i] = ($urandom_range(0, 99) < p);
        din[i] = 9'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    vin = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It adds configurable data width, bit period, parity and stop bits. It also adds a small input FIFO with a valid/ready handshake, so producers (e.g. network output stage) can queue words and the frames go out back-to-back with no idle gap. It sits between the on-chip result logic and the board TX pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 434, clk cycles per serial bit (>=2)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, input FIFO depth in words (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
data_in  in  DATA_BITS  word to transmit
valid_in  in  1  data_in valid; written when valid_in && ready_out
ready_out  out  1  FIFO not full
tx  out  1  serial line, idle high, registered
busy  out  1  a frame is in progress (state != IDLE)
done  out  1  one-cycle pulse at end of each frame
fifo_count  out  $clog2(FIFO_DEPTH+1)  words queued, not yet started

Behaviour:
- Reset (rst=1 at an edge):
  - tx=1, busy=0, done=0, ready_out=1, fifo_count=0.
  - FIFO is flushed; state goes to IDLE; bit and baud counters clear.
  - Reset has priority over all other events.
- FIFO write:
  - A write occurs on an edge where valid_in && ready_out; fifo_count increments that edge.
  - ready_out = (fifo_count != FIFO_DEPTH). It is computed from the registered count only; it does not see a same-cycle pop.
  - Writes while full are ignored with no side effects.
  - A simultaneous write and pop leaves fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, PAR, STOP.
  - IDLE, FIFO non-empty: at the next edge, pop the head into the shift register, tx<=0, go to START. A word written at edge k therefore drives tx low at edge k+1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles; shift right; after DATA_BITS bits go to PAR (PARITY!=0) or STOP.
  - PAR: tx = ^data for even parity, ~^data for odd parity, held CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - End of STOP, FIFO non-empty: pop and go straight to START with no idle cycle.
  - End of STOP, FIFO empty: go to IDLE.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- done is asserted during the final clock cycle of the last stop bit, once per frame, including back-to-back frames.
- busy=1 from the first START cycle through the final STOP cycle. It stays 1 continuously across back-to-back frames.
- The parity value is computed from the word latched at pop. data_in changing mid-frame has no effect.
- Reset mid-frame: at the next edge tx=1, busy=0, and the FIFO is emptied. No done pulse is produced.
- Illegal parameter values (PARITY>2, STOP_BITS not 1 or 2) are unsupported. Instantiation must stop elaboration with an error.

Test Plan:
(Defaults unless stated: DATA_BITS=8, CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1, FIFO_DEPTH=4; frame = 44 cycles.)
1. Assert rst for 3 cycles, then release -> tx=1, ready_out=1, busy=0, done=0, fifo_count=0.
2. Write 8'hAA once -> tx low at the next edge, then the sequence 0,0,1,0,1,0,1,0,1, parity 0, stop 1, each level held exactly 4 cycles. done pulses once in cycle 44. busy drops the cycle after.
3. PARITY=2, write 8'h01 -> parity bit 0. With PARITY=1, the same word -> parity bit 1.
4. Hold valid_in=1 for 6 consecutive cycles with data 1..6 -> words 1..5 accepted (the first is popped immediately); ready_out=0 on the 6th cycle so word 6 is dropped. tx then carries 5 gapless frames over 220 cycles, done pulses 5 times, and busy stays high throughout.
5. Queue 3 words, then assert rst during the 3rd data bit of frame 1 -> tx=1, busy=0, fifo_count=0 on the next edge. No done pulse occurs and the line stays idle afterwards.
6. DATA_BITS=7, PARITY=0, STOP_BITS=2, write 7'h55 -> frame length 40 cycles (10 bits x 4), no parity bit, stop high for 8 cycles.
